// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder state encoding, ACK/NACK levels and R/W bit encoding.
package i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StRxByte,
    StRxAck,
    StTxByte,
    StTxAck,
    StWaitStop
  } i2c_state_e;

  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NACK  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer plus edge-detect register for one asynchronous bus line.
module i2c_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], in_i};
    prev_d = sync_q[1];
  end

  // Reset to the idle-high bus level so release of reset never fakes an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~prev_q;
  assign fall_o  = ~sync_q[1] & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: oversampled START/STOP detection, 7-bit address match, ACKed writes, host-fed reads.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'b1100110
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rw,
  output logic       busy
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;
  logic start, stop;

  i2c_sync_edge u_scl_sync (
    .clk_i  (clk),
    .rst_ni (reset),
    .in_i   (SCL),
    .level_o(scl_level),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk_i  (clk),
    .rst_ni (reset),
    .in_i   (SDA),
    .level_o(sda_level),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  assign start = sda_fall & scl_level;
  assign stop  = sda_rise & scl_level;

  i2c_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [6:0] tx_shift_q, tx_shift_d;
  logic       oe_q, oe_d;
  logic       phase_q, phase_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load_q, tx_load_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    oe_d       = oe_q;
    phase_d    = phase_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;

    unique case (state_q)
      StIdle: ;
      StAddr: begin
        if (scl_rise) begin
          shift_d = {shift_q[5:0], sda_level};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (shift_q == SLAVE_ADDR) begin
              rw_d    = sda_level;
              phase_d = 1'b0;
              state_d = StAddrAck;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
      end
      // phase_q: 0 = ACK not yet driven, 1 = ACK on the bus
      StAddrAck: begin
        if (scl_fall) begin
          if (!phase_q) begin
            oe_d    = 1'b1;
            busy_d  = 1'b1;
            phase_d = 1'b1;
          end else begin
            cnt_d = 3'd0;
            if (rw_q == I2C_READ) begin
              tx_load_d  = 1'b1;
              tx_shift_d = tx_data[6:0];
              oe_d       = ~tx_data[7];
              state_d    = StTxByte;
            end else begin
              oe_d    = 1'b0;
              state_d = StRxByte;
            end
          end
        end
      end
      StRxByte: begin
        if (scl_rise) begin
          shift_d = {shift_q[5:0], sda_level};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rx_data_d  = {shift_q, sda_level};
            rx_valid_d = 1'b1;
            phase_d    = 1'b0;
            state_d    = StRxAck;
          end
        end
      end
      StRxAck: begin
        if (scl_fall) begin
          if (!phase_q) begin
            oe_d    = 1'b1;
            phase_d = 1'b1;
          end else begin
            oe_d    = 1'b0;
            cnt_d   = 3'd0;
            state_d = StRxByte;
          end
        end
      end
      StTxByte: begin
        if (scl_fall) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            oe_d    = 1'b0;
            phase_d = 1'b0;
            state_d = StTxAck;
          end else begin
            oe_d       = ~tx_shift_q[6];
            tx_shift_d = {tx_shift_q[5:0], 1'b0};
          end
        end
      end
      // phase_q: 1 once the master has ACKed and the next byte is due
      StTxAck: begin
        if (!phase_q && scl_rise) begin
          if (sda_level == I2C_ACK) phase_d = 1'b1;
          else                      state_d = StWaitStop;
        end else if (phase_q && scl_fall) begin
          cnt_d      = 3'd0;
          tx_load_d  = 1'b1;
          tx_shift_d = tx_data[6:0];
          oe_d       = ~tx_data[7];
          state_d    = StTxByte;
        end
      end
      StWaitStop: oe_d = 1'b0;
      default:    state_d = StIdle;
    endcase

    if (start) begin
      state_d    = StAddr;
      cnt_d      = 3'd0;
      oe_d       = 1'b0;
      busy_d     = 1'b0;
      rx_valid_d = 1'b0;
      tx_load_d  = 1'b0;
    end else if (stop) begin
      state_d    = StIdle;
      oe_d       = 1'b0;
      busy_d     = 1'b0;
      rx_valid_d = 1'b0;
      tx_load_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      shift_q    <= 7'd0;
      tx_shift_q <= 7'd0;
      oe_q       <= 1'b0;
      phase_q    <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      oe_q       <= oe_d;
      phase_q    <= phase_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
    end
  end

  assign SDA      = oe_q ? 1'b0 : 1'bz;
  assign tx_load  = tx_load_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rw       = rw_q;
  assign busy     = busy_q;

endmodule
